id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage processor. It registers decoded operands and control from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operand and opcode inputs `A`, `B` and `ALUControl`. It detects load-use hazards, requests an IF/ID stall, and inserts a bubble into EX. It also honours pipeline hold and branch flush.

## Interface
- `XLEN`, 32: datapath width.
- `RA_W`, 5: register address width.
- `ALUC_W`, 3: ALU opcode width.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in `RA_W`: source and destination register addresses.
- `id_rs_data`, `id_rt_data` in `XLEN`: register-file read data.
- `id_imm` in `XLEN`: sign-extended immediate.
- `id_alu_src` in 1: 1 selects `id_imm` for `B`; 1 also means `rt` is not a source for hazard purposes, except when `id_mem_write` is set.
- `id_alu_ctrl` in `ALUC_W`: opcode (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7).
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits.
- `hold` in 1: global pipeline freeze (memory stall).
- `flush` in 1: kill the instruction entering EX (taken branch).
- `exmem_reg_write` in 1, `exmem_rd` in `RA_W`, `exmem_result` in `XLEN`: EX/MEM producer.
- `memwb_reg_write` in 1, `memwb_rd` in `RA_W`, `memwb_result` in `XLEN`: MEM/WB producer.
- `A`, `B` out `XLEN`: ALU operands.
- `ALUControl` out `ALUC_W`: ALU opcode.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered controls, forwarded to EX/MEM.
- `ex_rd` out `RA_W`: destination register.
- `ex_store_data` out `XLEN`: forwarded `rt` value for stores.
- `stall_id` out 1: freeze PC and IF/ID this cycle.

## Operation
- **Register update priority per edge:**
  - `reset`: all fields cleared.
  - `flush`: bubble.
  - `hold`: retain instruction, refresh operands.
  - `stall_id`: bubble.
  - Otherwise: load from ID.
- **Bubble:** `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` = 0; `ALUControl` = 0; `rd`/`rs`/`rt` = 0. Data fields don't care; they are zeroed.
- **Forwarding (combinational, per source `rs`/`rt`):**
  - EX/MEM match (`exmem_reg_write`, `exmem_rd` == src, src != 0) has priority.
  - Otherwise MEM/WB match.
  - Otherwise the registered data.
  - Register 0 never forwards.
- **Operand outputs:**
  - `A` = forwarded rs.
  - `B` = registered imm if the registered `alu_src` is set, else forwarded rt.
  - `ex_store_data` = forwarded rt always.
- **Operand refresh on hold:** while `hold` is asserted, the rs/rt data registers reload with their forwarded values. This keeps operands correct after producers retire during the freeze.
- **Load-use detection:** `stall_id` = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_rd` != 0) & (`ex_rd` == `id_rs` | (`ex_rd` == `id_rt` & rt is a source)). The result is gated low by `hold` and by `flush`.

## Timing
- ID to `A`/`B`/`ALUControl`: 1 cycle.
- Forwarding adds 0 cycles.
- A load-use hazard costs exactly 1 bubble. `stall_id` is high for 1 cycle, then drops once the bubble occupies EX.
- **Reset values:** all outputs 0. `A`/`B` = 0 because registered data is 0 and rs = rt = 0.
- **Simultaneous events:**
  - `flush` with `stall_id` condition: bubble, `stall_id` = 0.
  - `hold` with `flush`: bubble (flush wins).
  - `hold` with a hazard: state held, `stall_id` = 0.
- **Reset mid-hold or mid-stall:** state cleared next edge, with no residual stall.

## Configuration
- **`ID_EX_FORWARDING_EN` defined:** behaviour as above.
- **Undefined:**
  - Forwarding muxes are removed: `A`/`B`/`ex_store_data` come straight from the registers.
  - Operand refresh on hold is removed.
  - `stall_id` additionally asserts on any RAW match of an ID source against a valid EX writer (`ex_reg_write`) or against `exmem_rd`/`exmem_reg_write`.
  - MEM/WB is covered by the register file's write-first read.

## Structure
- **Shared package `cpu_pkg`:**
  - ALU opcode constants ALU_ADD..ALU_SLTU.
  - Forward-select enum FWD_REG, FWD_EXMEM, FWD_MEMWB.
  - XLEN/RA_W defaults.
- **Sub-module `forward_unit`:** combinational. Takes a source address and both producers and returns a select, instantiated once each for rs and rt.
- **Hazard detection:** inline.

## Test plan
- **ALU path:** reset, then ID ADD with rs_data=5, rt_data=7, alu_src=0. Next cycle requires `A`=5, `B`=7, `ALUControl`=0, `ex_valid`=1.
- **Forward priority:** `ex` rs=3, exmem rd=3 result=0x11, memwb rd=3 result=0x22. Requires `A`=0x11. With exmem_reg_write=0, requires `A`=0x22. With rs=0, no forwarding.
- **Load-use:** lw r4 in EX (`ex_mem_read`=1), ID uses rs=4. Requires `stall_id`=1 for 1 cycle and `ex_valid`=0 the next cycle. Repeating with rt=4, alu_src=1, mem_write=0 requires no stall.
- **Flush with hazard:** `flush`=1 with a load-use hazard present. Requires `stall_id`=0 and bubble in EX next cycle.
- **Hold with retirement:** `hold` for 3 cycles while memwb forwards 0x33 to rs in cycle 1 only. After release requires `A`=0x33.
- **Macro off:** without the macro, exmem rd=2 matching ID rs=2 requires `stall_id`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, forward-select encoding and
// default datapath widths used by the pipeline stages.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int ALUC_W = 3;

    localparam logic [ALUC_W-1:0] ALU_ADD  = 3'd0;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 3'd1;
    localparam logic [ALUC_W-1:0] ALU_AND  = 3'd2;
    localparam logic [ALUC_W-1:0] ALU_OR   = 3'd3;
    localparam logic [ALUC_W-1:0] ALU_XOR  = 3'd4;
    localparam logic [ALUC_W-1:0] ALU_NOR  = 3'd5;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 3'd6;
    localparam logic [ALUC_W-1:0] ALU_SLTU = 3'd7;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Producer match for one source register: EX/MEM beats MEM/WB, r0 never
// matches. Ports: src, exmem_reg_write/exmem_rd, memwb_reg_write/memwb_rd -> sel.
module forward_unit
    import cpu_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    output fwd_sel_e        sel
);

    logic ex_hit;
    logic wb_hit;

    assign ex_hit = exmem_reg_write && (exmem_rd == src) && (src != '0);
    assign wb_hit = !ex_hit && memwb_reg_write && (memwb_rd == src) && (src != '0);

    always_comb begin
        sel = FWD_REG;
        unique case (1'b1)
            ex_hit:  sel = FWD_EXMEM;
            wb_hit:  sel = FWD_MEMWB;
            default: sel = FWD_REG;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and bubble
// insertion, hold and flush. Inputs: id_* decoded instruction, hold, flush,
// exmem_*/memwb_* producers. Outputs: A, B, ALUControl, ex_* controls,
// ex_store_data, stall_id. Macro ID_EX_FORWARDING_EN enables forwarding;
// without it, RAW hazards on EX/EX-MEM producers stall instead.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [XLEN-1:0]   id_rs_data,
    input  logic [XLEN-1:0]   id_rt_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [ALUC_W-1:0] id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              hold,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   A,
    output logic [XLEN-1:0]   B,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [RA_W-1:0]   ex_rd,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              stall_id
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [ALUC_W-1:0] alu_ctrl;
        logic [RA_W-1:0]   rd;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d_load;

    logic [XLEN-1:0] rs_fwd;
    logic [XLEN-1:0] rt_fwd;
    fwd_sel_e        rs_sel;
    fwd_sel_e        rt_sel;
    logic [RA_W-1:0] rs_src;
    logic [RA_W-1:0] rt_src_addr;

    logic rt_is_src;
    logic load_use;
    logic raw_stall;

    assign rt_is_src = !id_alu_src || id_mem_write;

`ifdef ID_EX_FORWARDING_EN
    assign rs_src      = q.rs;
    assign rt_src_addr = q.rt;
`else
    // Without forwarding the units watch the ID sources, so an EX/MEM
    // match becomes a stall condition instead of a mux select.
    assign rs_src      = id_rs;
    assign rt_src_addr = id_rt;
`endif

    forward_unit #(.RA_W(RA_W)) u_fwd_rs (
        .src             (rs_src),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (rs_sel)
    );

    forward_unit #(.RA_W(RA_W)) u_fwd_rt (
        .src             (rt_src_addr),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (rt_sel)
    );

`ifdef ID_EX_FORWARDING_EN
    always_comb begin
        rs_fwd = q.rs_data;
        rt_fwd = q.rt_data;
        unique case (rs_sel)
            FWD_EXMEM: rs_fwd = exmem_result;
            FWD_MEMWB: rs_fwd = memwb_result;
            default:   rs_fwd = q.rs_data;
        endcase
        unique case (rt_sel)
            FWD_EXMEM: rt_fwd = exmem_result;
            FWD_MEMWB: rt_fwd = memwb_result;
            default:   rt_fwd = q.rt_data;
        endcase
    end

    assign raw_stall = 1'b0;
`else
    logic unused_results;
    logic ex_hit_rs;
    logic ex_hit_rt;

    assign unused_results = ^{exmem_result, memwb_result};
    assign rs_fwd = q.rs_data;
    assign rt_fwd = q.rt_data;

    // A valid writer sitting in EX conflicts with any ID source.
    assign ex_hit_rs = q.valid && q.reg_write && (q.rd == id_rs) && (id_rs != '0);
    assign ex_hit_rt = q.valid && q.reg_write && (q.rd == id_rt) && (id_rt != '0);

    assign raw_stall = id_valid && (
        ex_hit_rs || (rs_sel == FWD_EXMEM) ||
        (rt_is_src && (ex_hit_rt || (rt_sel == FWD_EXMEM))));
`endif

    assign load_use = id_valid && q.valid && q.mem_read && (q.rd != '0) &&
        ((q.rd == id_rs) || ((q.rd == id_rt) && rt_is_src));

    assign stall_id = (load_use || raw_stall) && !hold && !flush;

    always_comb begin
        d_load           = '0;
        d_load.valid     = id_valid;
        d_load.reg_write = id_reg_write;
        d_load.mem_read  = id_mem_read;
        d_load.mem_write = id_mem_write;
        d_load.alu_src   = id_alu_src;
        d_load.alu_ctrl  = id_alu_ctrl;
        d_load.rd        = id_rd;
        d_load.rs        = id_rs;
        d_load.rt        = id_rt;
        d_load.rs_data   = id_rs_data;
        d_load.rt_data   = id_rt_data;
        d_load.imm       = id_imm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (hold) begin
`ifdef ID_EX_FORWARDING_EN
            // Capture values from producers that retire during the freeze.
            q.rs_data <= rs_fwd;
            q.rt_data <= rt_fwd;
`endif
        end else if (stall_id) begin
            q <= '0;
        end else begin
            q <= d_load;
        end
    end

    assign A             = rs_fwd;
    assign B             = q.alu_src ? q.imm : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ALUControl    = q.alu_ctrl;
    assign ex_valid      = q.valid;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_rd         = q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, hand-written corner
// sequences and a randomized run against an instruction-level model.
module tb_id_ex_stage;
    import cpu_pkg::*;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src;
    logic [2:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        hold, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] A, B, ex_store_data;
    logic [2:0]  ALUControl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic        stall_id;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .hold(hold), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .A(A), .B(B), .ALUControl(ALUControl), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .stall_id(stall_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alu_src = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        hold = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic as, input logic [2:0] ctrl,
                         input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src = as; id_alu_ctrl = ctrl;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic        as;
        logic [2:0]  ctrl;
        logic        rw, mr, mw;
        logic [31:0] ea, eb, est;
    } vec_t;

    // Model of the instruction currently occupying EX.
    typedef struct {
        bit        valid, rw, mr, mw, as;
        bit [2:0]  ctrl;
        bit [4:0]  rd, rs, rt;
        bit [31:0] rsd, rtd, imm;
    } slot_t;

    slot_t m;

    function automatic logic [31:0] fwd_val(input logic [4:0] src, input logic [31:0] regd);
        if (!FWD) return regd;
        if (src != 0 && exmem_reg_write && exmem_rd == src) return exmem_result;
        if (src != 0 && memwb_reg_write && memwb_rd == src) return memwb_result;
        return regd;
    endfunction

    function automatic bit depends(input logic [4:0] r, input bit rtsrc);
        return r != 0 && (id_rs == r || (rtsrc && id_rt == r));
    endfunction

    function automatic bit exp_stall();
        bit rtsrc, lu, raw;
        rtsrc = !id_alu_src || id_mem_write;
        lu = id_valid && m.valid && m.mr && depends(m.rd, rtsrc);
        raw = 0;
        if (!FWD)
            raw = id_valid && ((m.valid && m.rw && depends(m.rd, rtsrc)) ||
                               (exmem_reg_write && depends(exmem_rd, rtsrc)));
        return (lu || raw) && !hold && !flush;
    endfunction

    vec_t vt[6];

    initial begin
        vt[0] = '{5'd20, 5'd21, 5'd1, 32'd5, 32'd7, 32'h100, 1'b0, ALU_ADD,
                  1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd7};
        vt[1] = '{5'd22, 5'd23, 5'd2, 32'hdeadbeef, 32'h12345678, 32'hfffffff0, 1'b1, ALU_SUB,
                  1'b1, 1'b0, 1'b0, 32'hdeadbeef, 32'hfffffff0, 32'h12345678};
        vt[2] = '{5'd24, 5'd25, 5'd3, 32'h0, 32'hffffffff, 32'h4, 1'b1, ALU_ADD,
                  1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'hffffffff};
        vt[3] = '{5'd26, 5'd27, 5'd0, 32'h1, 32'h2, 32'h8, 1'b1, ALU_AND,
                  1'b0, 1'b0, 1'b1, 32'h1, 32'h8, 32'h2};
        vt[4] = '{5'd28, 5'd29, 5'd5, 32'h80000000, 32'h7fffffff, 32'h0, 1'b0, ALU_SLTU,
                  1'b1, 1'b0, 1'b0, 32'h80000000, 32'h7fffffff, 32'h7fffffff};
        vt[5] = '{5'd30, 5'd31, 5'd9, 32'haaaa5555, 32'h0f0f0f0f, 32'h3, 1'b0, ALU_NOR,
                  1'b1, 1'b0, 1'b0, 32'haaaa5555, 32'h0f0f0f0f, 32'h0f0f0f0f};

        idle();
        reset = 1;
        tick();
        tick();
        chk("reset_A", A, 0);
        chk("reset_B", B, 0);
        chk("reset_ctrl", {29'd0, ALUControl}, 0);
        chk("reset_ctl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        chk("reset_rd", {27'd0, ex_rd}, 0);
        chk("reset_store", ex_store_data, 0);
        chk("reset_stall", {31'd0, stall_id}, 0);
        reset = 0;

        // ALU path
        issue(1, 2, 3, 5, 7, 0, 0, ALU_ADD, 1, 0, 0);
        tick();
        idle();
        #1;
        chk("alu_A", A, 5);
        chk("alu_B", B, 7);
        chk("alu_ctrl", {29'd0, ALUControl}, ALU_ADD);
        chk("alu_valid", {31'd0, ex_valid}, 1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            issue(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].rsd, vt[i].rtd, vt[i].imm,
                  vt[i].as, vt[i].ctrl, vt[i].rw, vt[i].mr, vt[i].mw);
            tick();
            chk("tbl_A", A, vt[i].ea);
            chk("tbl_B", B, vt[i].eb);
            chk("tbl_store", ex_store_data, vt[i].est);
            chk("tbl_ctrl", {29'd0, ALUControl}, {29'd0, vt[i].ctrl});
            chk("tbl_rd", {27'd0, ex_rd}, {27'd0, vt[i].rd});
            chk("tbl_ctl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
                {28'd0, 1'b1, vt[i].rw, vt[i].mr, vt[i].mw});
            chk("tbl_stall", {31'd0, stall_id}, 0);
        end

        // Forward priority
        idle();
        issue(3, 0, 8, 32'h99, 0, 0, 0, ALU_OR, 1, 0, 0);
        tick();
        idle();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1;
        chk("fwd_exmem", A, FWD ? 32'h11 : 32'h99);
        exmem_reg_write = 0;
        #1;
        chk("fwd_memwb", A, FWD ? 32'h22 : 32'h99);
        idle();
        issue(0, 0, 8, 32'h5, 32'h6, 0, 0, ALU_OR, 1, 0, 0);
        tick();
        idle();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h22;
        #1;
        chk("fwd_r0_A", A, 32'h5);
        chk("fwd_r0_st", ex_store_data, 32'h6);

        // Load-use on rs
        idle();
        issue(1, 2, 4, 0, 0, 0, 1, ALU_ADD, 1, 1, 0);
        tick();
        issue(4, 5, 6, 0, 0, 0, 0, ALU_SUB, 1, 0, 0);
        #1;
        chk("lu_stall", {31'd0, stall_id}, 1);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 0);
        chk("lu_stall_drop", {31'd0, stall_id}, 0);
        tick();
        chk("lu_after_valid", {31'd0, ex_valid}, 1);
        chk("lu_after_rd", {27'd0, ex_rd}, 6);

        // rt with alu_src is not a source unless storing
        issue(1, 2, 4, 0, 0, 0, 1, ALU_ADD, 1, 1, 0);
        tick();
        issue(5, 4, 6, 0, 0, 0, 1, ALU_ADD, 1, 0, 0);
        #1;
        chk("lu_imm_nostall", {31'd0, stall_id}, 0);
        id_mem_write = 1;
        #1;
        chk("lu_store_stall", {31'd0, stall_id}, 1);

        // Load to r0 never stalls
        issue(1, 2, 0, 0, 0, 0, 1, ALU_ADD, 1, 1, 0);
        tick();
        issue(0, 0, 6, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        #1;
        chk("lu_r0", {31'd0, stall_id}, 0);

        // Flush with hazard
        issue(1, 2, 4, 0, 0, 0, 1, ALU_SLTU, 1, 1, 0);
        tick();
        issue(4, 5, 6, 0, 0, 0, 0, ALU_XOR, 1, 0, 0);
        flush = 1;
        #1;
        chk("flush_stall", {31'd0, stall_id}, 0);
        tick();
        flush = 0;
        #1;
        chk("flush_valid", {31'd0, ex_valid}, 0);
        chk("flush_ctrl", {29'd0, ALUControl}, 0);
        chk("flush_rd", {27'd0, ex_rd}, 0);

        // Hold with hazard
        idle();
        issue(1, 2, 4, 0, 0, 0, 1, ALU_ADD, 1, 1, 0);
        tick();
        issue(4, 5, 6, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        hold = 1;
        #1;
        chk("hold_stall", {31'd0, stall_id}, 0);
        tick();
        chk("hold_keep_mr", {31'd0, ex_mem_read}, 1);
        chk("hold_keep_rd", {27'd0, ex_rd}, 4);

        // Hold with retirement
        idle();
        issue(6, 0, 7, 32'h10, 0, 0, 0, ALU_XOR, 1, 0, 0);
        tick();
        idle();
        hold = 1;
        memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h33;
        tick();
        memwb_reg_write = 0; memwb_result = 0;
        tick();
        tick();
        hold = 0;
        #1;
        chk("hold_ret_A", A, FWD ? 32'h33 : 32'h10);
        chk("hold_ret_ctrl", {29'd0, ALUControl}, ALU_XOR);
        chk("hold_ret_valid", {31'd0, ex_valid}, 1);

        // EX/MEM RAW without a load in EX
        exmem_reg_write = 1; exmem_rd = 2; exmem_result = 32'h77;
        issue(2, 9, 8, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        #1;
        chk("raw_exmem_rs", {31'd0, stall_id}, FWD ? 0 : 1);
        issue(9, 2, 8, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        #1;
        chk("raw_exmem_rt", {31'd0, stall_id}, FWD ? 0 : 1);

        // Reset mid-stall
        idle();
        issue(1, 2, 4, 0, 0, 0, 1, ALU_ADD, 1, 1, 0);
        tick();
        issue(4, 5, 6, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        #1;
        chk("rst_pre_stall", {31'd0, stall_id}, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 0);
        chk("rst_mr", {31'd0, ex_mem_read}, 0);
        chk("rst_rd", {27'd0, ex_rd}, 0);
        chk("rst_stall", {31'd0, stall_id}, 0);

        // Randomized run against the model
        idle();
        reset = 1;
        tick();
        m = '{default: 0};
        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 39) == 0);
            hold            = ($urandom_range(0, 5) == 0);
            flush           = ($urandom_range(0, 7) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_rd           = 5'($urandom_range(0, 3));
            id_rs_data      = $urandom;
            id_rt_data      = $urandom;
            id_imm          = $urandom;
            id_alu_src      = 1'($urandom_range(0, 1));
            id_alu_ctrl     = 3'($urandom_range(0, 7));
            id_reg_write    = 1'($urandom_range(0, 1));
            id_mem_read     = ($urandom_range(0, 2) == 0);
            id_mem_write    = ($urandom_range(0, 4) == 0);
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_result    = $urandom;
            #1;
            begin
                logic [31:0] ers, ert;
                bit st;
                ers = fwd_val(m.rs, m.rsd);
                ert = fwd_val(m.rt, m.rtd);
                st  = exp_stall();
                chk("rnd_A", A, ers);
                chk("rnd_B", B, m.as ? m.imm : ert);
                chk("rnd_store", ex_store_data, ert);
                chk("rnd_ctrl", {29'd0, ALUControl}, {29'd0, m.ctrl});
                chk("rnd_rd", {27'd0, ex_rd}, {27'd0, m.rd});
                chk("rnd_ctl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
                    {28'd0, m.valid, m.rw, m.mr, m.mw});
                chk("rnd_stall", {31'd0, stall_id}, {31'd0, st});
                if (reset || flush) begin
                    m = '{default: 0};
                end else if (hold) begin
                    m.rsd = ers;
                    m.rtd = ert;
                end else if (st) begin
                    m = '{default: 0};
                end else begin
                    m.valid = id_valid;   m.rw = id_reg_write;
                    m.mr = id_mem_read;   m.mw = id_mem_write;
                    m.as = id_alu_src;    m.ctrl = id_alu_ctrl;
                    m.rd = id_rd;         m.rs = id_rs;   m.rt = id_rt;
                    m.rsd = id_rs_data;   m.rtd = id_rt_data;
                    m.imm = id_imm;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
